// File: rtl/barrel_shift_pkg.sv
// barrel_shift_pkg: op and state encodings shared by the shift/rotate issue stage
package barrel_shift_pkg;
  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;
endpackage

// File: rtl/right_rotator.sv
// right_rotator: combinational rotate-right of in_a by in_amt
module right_rotator #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] in_amt,
  output logic [N-1:0]  out_rot
);
  logic [2*N-1:0] dbl;
  assign dbl = {in_a, in_a} >> in_amt;
  assign out_rot = dbl[N-1:0];
endmodule

// File: rtl/rotate_issue_stage.sv
// rotate_issue_stage: registered ROR/SRL/SRA issue stage with one-entry skid buffer
// SHIFT_OPS_EN enables SRL/SRA; without it every request executes as ROR.
module rotate_issue_stage #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] in_amt,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);
  import barrel_shift_pkg::*;
  logic [N-1:0] rot, res;
  logic [1:0] state_q, state_d;
  logic [N-1:0] out_q, out_d, skid_q, skid_d;
  logic acc, take;
  right_rotator #(.N(N)) u_rot (.in_a(in_a), .in_amt(in_amt), .out_rot(rot));
`ifdef SHIFT_OPS_EN
  logic [N-1:0] mask;
  always_comb begin
    mask = {N{1'b1}} >> in_amt;
    res = (in_op == OP_SRL) ? rot & mask :
          (in_op == OP_SRA) ? (rot & mask) | (~mask & {N{in_a[N-1]}}) : rot;
  end
`else
  logic unused_op;
  assign unused_op = ^in_op;
  assign res = rot;
`endif
  assign in_ready  = state_q != ST_FULL;
  assign out_valid = state_q != ST_EMPTY;
  assign out_data  = out_q;
  assign acc  = in_valid && in_ready;
  assign take = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    skid_d = skid_q;
    case (state_q)
      ST_EMPTY: if (acc) begin
        state_d = ST_BUSY;
        out_d = res;
      end
      ST_BUSY: if (acc && take) out_d = res;
      else if (acc) begin
        state_d = ST_FULL;
        skid_d = res;
      end
      else if (take) state_d = ST_EMPTY;
      ST_FULL: if (take) begin
        state_d = ST_BUSY;
        out_d = skid_q;
        skid_d = '0;
      end
      default: state_d = ST_EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      skid_q <= skid_d;
    end
endmodule

// File: tb/tb_rotate_issue_stage.sv
// tb_rotate_issue_stage: scoreboard bench for rotate_issue_stage (N=8)
module tb_rotate_issue_stage;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [7:0] in_a = 0, out_data, exp_in = 0;
  logic [2:0] in_amt = 0;
  logic [1:0] in_op = 0;
  logic [7:0] q[$];
  int tests = 0, fails = 0;
  bit rnd_done;

  rotate_issue_stage #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] s, input logic [1:0] op);
    logic [7:0] r;
    r = (a >> s) | (a << (8 - s));
`ifdef SHIFT_OPS_EN
    if (op == 2'b01) r = a >> s;
    else if (op == 2'b10) r = $signed(a) >>> s;
`endif
    return r;
  endfunction

  // output side checked before input side so a same-cycle push never satisfies its own pop
  always @(negedge clk) if (!rst) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious", 1, 0);
      else chk("data", out_data, q.pop_front());
    end
    if (in_valid && in_ready) q.push_back(exp_in);
  end

  task automatic send(input logic [7:0] a, input logic [2:0] s, input logic [1:0] op, input logic [7:0] e);
    int n;
    in_valid = 1; in_a = a; in_amt = s; in_op = op; exp_in = e;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 100) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("latency", out_valid, 1);
  endtask

  initial begin
    logic [7:0] sra_exp;
    #1 chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1 rst = 0;

    // reset while FULL: skid contents must never be emitted
    out_ready = 0;
    send(8'h5A, 0, 0, 8'h5A);
    send(8'h3C, 0, 0, 8'h3C);
    chk("full_ready", in_ready, 0);
    rst = 1; #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ready", in_ready, 1);
    q.delete();
    in_valid = 1;
    @(posedge clk); #1 in_valid = 0; rst = 0; out_ready = 1;
    repeat (3) begin
      @(negedge clk) chk("post_rst_idle", out_valid, 0);
    end
    @(posedge clk); #1;

    for (int s = 0; s < 8; s++) begin
      send(8'h0C, s[2:0], 0, s == 3 ? 8'h81 : s == 7 ? 8'h18 : model(8'h0C, s[2:0], 0));
      chk("sweep_ready", in_ready, 1);
    end

`ifdef SHIFT_OPS_EN
    sra_exp = 8'hE3;
`else
    sra_exp = 8'h23;
`endif
    send(8'h8C, 2, 2'b00, 8'h23);
    send(8'h8C, 2, 2'b01, 8'h23);
    send(8'h8C, 2, 2'b10, sra_exp);
    send(8'h8C, 2, 2'b11, 8'h23);
    for (int op = 0; op < 4; op++) send(8'hA5, 0, op[1:0], 8'hA5);

    // back-pressure: A0 held in output, A1 in skid, A2 stalls until out_ready rises
    fork
      begin
        send(8'h11, 0, 0, 8'h11);
        send(8'h22, 0, 0, 8'h22);
        send(8'h33, 0, 0, 8'h33);
        send(8'h44, 0, 0, 8'h44);
      end
      begin
        @(posedge clk); #1 out_ready = 0;
        @(posedge clk); #1;
        chk("bp_ready", in_ready, 0);
        chk("bp_hold", out_data, 8'h11);
        repeat (3) @(posedge clk);
        #1 chk("bp_stable", out_data, 8'h11);
        chk("bp_still_full", in_ready, 0);
        out_ready = 1;
      end
    join
    @(posedge clk); #1;

    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] a;
          logic [2:0] s;
          logic [1:0] op;
          a = 8'($urandom); s = 3'($urandom); op = 2'($urandom);
          send(a, s, op, model(a, s, op));
        end
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk); #2 out_ready = 1'($urandom);
      end
    join
    out_ready = 1;
    for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
